// File: rtl/fp16_normalize_pack_if.sv
// Handshake bundle for the FP16 normalize/round/pack back end.
// Upstream drives the operand side; downstream drives out_ready.
interface fp16_normalize_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [11:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;
    logic        out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_overflow, out_underflow, out_inexact, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_result,
        output out_overflow, out_underflow, out_inexact, out_zero
    );
endinterface

// File: rtl/fp16_normalize_pack.sv
// FP16 add/sub back end: normalize the mantissa sum, round to
// nearest-even and pack a binary16 result with status flags.
module fp16_normalize_pack #(
    parameter int MAX_LSHIFT = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp16_normalize_pack_if.slave  io
);

    localparam int CW = $clog2(MAX_LSHIFT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LSHIFT);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_e;

    state_e        state_q, state_d;
    logic          sign_q, sign_d;
    logic [5:0]    exp_q, exp_d;
    logic [11:0]   mant_q, mant_d;
    logic          g_q, g_d, r_q, r_d, s_q, s_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   res_q, res_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          inx_q, inx_d, zf_q, zf_d;

    logic          is_zero, do_rsh, do_lsh;
    logic          inc, inexact;
    logic [11:0]   sum, mant_r;
    logic [5:0]    exp_r;

    assign is_zero = (mant_q == 12'd0) && !(g_q | r_q | s_q);
    assign do_rsh  = mant_q[11];
    assign do_lsh  = !do_rsh && !is_zero && !mant_q[10]
                     && (exp_q > 6'd1) && (cnt_q != CNT_MAX);

    // Rounded values; sum cannot exceed 12 bits since bit 11 is clear here.
    assign inc     = g_q & (r_q | s_q | mant_q[0]);
    assign inexact = g_q | r_q | s_q;
    assign sum     = mant_q + 12'(inc);
    assign mant_r  = sum[11] ? {1'b0, sum[11:1]} : sum;
    assign exp_r   = exp_q + 6'(sum[11]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (io.in_valid) state_d = NORM;
            NORM:  if (!do_lsh)     state_d = ROUND;
            ROUND: state_d = OUT;
            OUT:   if (io.out_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready      = (state_q == IDLE);
        io.out_valid     = (state_q == OUT);
        io.out_result    = res_q;
        io.out_overflow  = ovf_q;
        io.out_underflow = unf_q;
        io.out_inexact   = inx_q;
        io.out_zero      = zf_q;
    end

    always_comb begin
        sign_d = sign_q;
        exp_d  = exp_q;
        mant_d = mant_q;
        g_d    = g_q;
        r_d    = r_q;
        s_d    = s_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        inx_d  = inx_q;
        zf_d   = zf_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    sign_d = io.in_sign;
                    exp_d  = {1'b0, io.in_exp};
                    mant_d = io.in_mant;
                    {g_d, r_d, s_d} = io.in_grs;
                    zero_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            NORM: begin
                if (do_rsh) begin
                    mant_d = {1'b0, mant_q[11:1]};
                    g_d    = mant_q[0];
                    r_d    = g_q;
                    s_d    = r_q | s_q;
                    exp_d  = exp_q + 6'd1;
                end else if (is_zero) begin
                    zero_d = 1'b1;
                end else if (do_lsh) begin
                    mant_d = {mant_q[10:0], g_q};
                    g_d    = r_q;
                    r_d    = s_q;
                    exp_d  = exp_q - 6'd1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ROUND: begin
                mant_d = mant_r;
                exp_d  = exp_r;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
                zf_d   = 1'b0;
                inx_d  = inexact;
                if (zero_q) begin
                    res_d = 16'h0000;
                    zf_d  = 1'b1;
                    inx_d = 1'b0;
                end else if (exp_r >= 6'd31) begin
                    res_d = {sign_q, 5'h1F, 10'h000};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (!mant_r[10]) begin
                    res_d = {sign_q, 5'h00, mant_r[9:0]};
                    unf_d = inexact;
                end else begin
                    res_d = {sign_q, exp_r[4:0], mant_r[9:0]};
                end
            end
            OUT: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            g_q    <= 1'b0;
            r_q    <= 1'b0;
            s_q    <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inx_q  <= 1'b0;
            zf_q   <= 1'b0;
        end else begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            g_q    <= g_d;
            r_q    <= r_d;
            s_q    <= s_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            inx_q  <= inx_d;
            zf_q   <= zf_d;
        end
    end

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Directed and randomized bench for fp16_normalize_pack with an
// arithmetic reference model of normalize/round/pack.
module tb_fp16_normalize_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fp16_normalize_pack_if bus();

    fp16_normalize_pack #(.MAX_LSHIFT(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.out_overflow, bus.out_underflow,
                bus.out_inexact, bus.out_zero};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value is treated as a 15-bit integer {mant, g, r, s}.
    task automatic model(input bit sg, input int e0, input int m,
                         input int grs, output logic [15:0] res,
                         output logic [3:0] fl, output int lat);
        int  v, e, n, keep, rem;
        bit  zero, inx, inc;
        v = m * 8 + grs;
        e = e0;
        n = 0;
        zero = 0;
        if (v >= (1 << 14)) begin
            v = (v >> 1) | (v & 1);
            e = e + 1;
        end else if (v == 0) begin
            zero = 1;
        end else begin
            while (v < (1 << 13) && e > 1 && n < 11) begin
                v = ((v << 1) | (v & 1)) & 32'h7FFF;
                e = e - 1;
                n = n + 1;
            end
        end
        keep = v >> 3;
        rem  = v & 7;
        inx  = (rem != 0);
        inc  = (rem > 4) || (rem == 4 && (keep % 2) == 1);
        keep = keep + int'(inc);
        if (keep >= 2048) begin
            keep = keep >> 1;
            e = e + 1;
        end
        lat = 3 + n;
        if (zero) begin
            res = 16'h0000;
            fl  = 4'b0001;
        end else if (e >= 31) begin
            res = {sg, 5'h1F, 10'h000};
            fl  = 4'b1010;
        end else if (keep < 1024) begin
            res = {sg, 5'h00, 10'(keep)};
            fl  = {1'b0, inx, inx, 1'b0};
        end else begin
            res = {sg, 5'(e), 10'(keep)};
            fl  = {2'b00, inx, 1'b0};
        end
    endtask

    task automatic run(input bit sg, input logic [4:0] e,
                       input logic [11:0] m, input logic [2:0] grs,
                       input logic [15:0] xr, input logic [3:0] xf,
                       input int xl, input int hold);
        int cyc;
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_sign   = sg;
        bus.in_exp    = e;
        bus.in_mant   = m;
        bus.in_grs    = grs;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(xl));
        chk("result", 32'(bus.out_result), 32'(xr));
        chk("flags", 32'(flags()), 32'(xf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_result", 32'(bus.out_result), 32'(xr));
            chk("hold_flags", 32'(flags()), 32'(xf));
        end
        if (hold != 0) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        chk("result_keep", 32'(bus.out_result), 32'(xr));
    endtask

    initial begin
        logic [15:0] xr;
        logic [3:0]  xf;
        int          xl, e, m, g;
        bit          sg;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_grs    = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.out_result), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        run(0, 15, 12'h800, 3'b000, 16'h4000, 4'b0000, 3, 0);
        run(1, 15, 12'h001, 3'b000, 16'h9400, 4'b0000, 13, 0);
        run(1, 12, 12'h000, 3'b000, 16'h0000, 4'b0001, 3, 0);
        run(0, 3, 12'h001, 3'b000, 16'h0004, 4'b0000, 5, 0);
        run(0, 15, 12'h401, 3'b100, 16'h3C02, 4'b0010, 3, 0);
        run(0, 15, 12'h400, 3'b100, 16'h3C00, 4'b0010, 3, 0);
        run(0, 15, 12'h400, 3'b110, 16'h3C01, 4'b0010, 3, 0);
        run(0, 30, 12'h800, 3'b000, 16'h7C00, 4'b1010, 3, 0);
        run(1, 30, 12'h7FF, 3'b110, 16'hFC00, 4'b1010, 3, 0);
        run(0, 1, 12'h001, 3'b100, 16'h0002, 4'b0110, 3, 0);
        run(0, 15, 12'h800, 3'b000, 16'h4000, 4'b0000, 3, 5);

        // Abort a deep-cancellation bundle while it is shifting.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 5'd15;
        bus.in_mant  = 12'h001;
        bus.in_grs   = 3'b000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", 32'(bus.out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        repeat (15) begin
            @(posedge clk);
            #1;
            chk("midrst_quiet", 32'(bus.out_valid), 32'd0);
        end
        run(0, 15, 12'h401, 3'b100, 16'h3C02, 4'b0010, 3, 0);

        for (int i = 0; i < 200; i++) begin
            sg = 1'($urandom_range(0, 1));
            e  = int'($urandom_range(1, 30));
            m  = int'($urandom_range(0, 4095));
            g  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) m = int'($urandom_range(0, 63));
            if (m == 0) g = 0;
            model(sg, e, m, g, xr, xf, xl);
            run(sg, 5'(e), 12'(m), 3'(g), xr, xf, xl,
                int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
